inta_sequencer: RTL and testbench

CPU-side interrupt acknowledge initiator for the 8259-compatible PIC. It watches the PIC's INT line, runs the two-pulse INTA handshake, and captures the vector byte driven during the second pulse. It hands that vector to the core over a valid/ready handshake. On core request it issues the non-specific EOI write (OCW2 = 0x20) back to the PIC. It sits between the core's interrupt logic and the PIC data bus and cascade master.

---
 rtl/pic_bus_pkg.sv | 20 ++
 rtl/sync2.sv | 21 ++
 rtl/inta_sequencer.sv | 149 ++++++++++++++
 tb/tb_inta_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared definitions for the 8259 bus side: sequencer states, OCW2 command byte
// and A0 encodings.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAck1,
    StGap,
    StAck2,
    StDeliver,
    StEoiSetup,
    StEoiWr,
    StEoiHold
  } state_t;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;
  localparam logic       A0_CMD      = 1'b0;
  localparam logic       A0_DATA     = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side INTA initiator: runs the two-pulse acknowledge, hands the captured vector
// to the core over valid/ready, and issues the non-specific EOI write on request.
module inta_sequencer
  import pic_bus_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter logic [7:0]  EOI_BYTE     = OCW2_NS_EOI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       irq_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  input  logic       vector_ready,
  input  logic       eoi_req,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy
);

  localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic            int_sync;
  logic            eoi_pending;
  state_t          state, state_d;
  logic [CntW-1:0] cnt, cnt_d;
  logic            cnt_done;
  logic            ack_low_d;
  logic            eoi_win_d;

  sync2 u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_req),
    .q   (int_sync)
  );

  assign cnt_done = (cnt == CntOne);

  // Counter is loaded on entry to each timed phase; the phase ends when it reads 1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      StIdle: begin
        if (eoi_pending) begin
          state_d = StEoiSetup;
        end else if (int_sync && irq_enable) begin
          state_d = StAck1;
          cnt_d   = PulseLoad;
        end
      end
      StAck1: begin
        if (cnt_done) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt - CntOne;
        end
      end
      StGap: begin
        if (cnt_done) begin
          state_d = StAck2;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt - CntOne;
        end
      end
      StAck2: begin
        if (cnt_done) begin
          state_d = StDeliver;
        end else begin
          cnt_d = cnt - CntOne;
        end
      end
      StDeliver: begin
        if (vector_valid && vector_ready) begin
          state_d = StIdle;
        end
      end
      StEoiSetup: begin
        state_d = StEoiWr;
        cnt_d   = PulseLoad;
      end
      StEoiWr: begin
        if (cnt_done) begin
          state_d = StEoiHold;
        end else begin
          cnt_d = cnt - CntOne;
        end
      end
      StEoiHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ack_low_d = (state_d == StAck1) || (state_d == StAck2);
  assign eoi_win_d = (state_d == StEoiSetup) || (state_d == StEoiWr) || (state_d == StEoiHold);

  // Outputs are registered from the next state so every strobe is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= '0;
      eoi_pending  <= 1'b0;
      inta_n       <= 1'b1;
      cs_n         <= 1'b1;
      wr_n         <= 1'b1;
      a0           <= A0_CMD;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      // Entry to EOI_SETUP consumes the request; repeats while pending simply merge.
      eoi_pending  <= (state_d == StEoiSetup) ? 1'b0 : (eoi_pending | eoi_req);
      inta_n       <= ~ack_low_d;
      cs_n         <= ~eoi_win_d;
      wr_n         <= (state_d != StEoiWr);
      a0           <= A0_CMD;
      data_out     <= eoi_win_d ? EOI_BYTE : 8'h00;
      data_oe      <= eoi_win_d;
      vector_valid <= (state_d == StDeliver);
      busy         <= (state_d != StIdle);
      if (state == StAck2 && cnt_done) begin
        vector_out <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios plus random traffic, all checked against a
// cycle-timeline reference model built from the acknowledge/EOI phase lengths.
module tb_inta_sequencer;

  localparam int         P   = 2;
  localparam int         G   = 1;
  localparam logic [7:0] EOI = 8'h20;

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic       int_req      = 1'b0;
  logic       irq_enable   = 1'b0;
  logic [7:0] data_in      = 8'h00;
  logic       vector_ready = 1'b0;
  logic       eoi_req      = 1'b0;
  logic       inta_n;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;

  inta_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .EOI_BYTE     (EOI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .irq_enable   (irq_enable),
    .data_in      (data_in),
    .inta_n       (inta_n),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .eoi_req      (eoi_req),
    .cs_n         (cs_n),
    .wr_n         (wr_n),
    .a0           (a0),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Each model entry describes what the bus should look like during one clock.
  typedef enum int {KIdle, KAckLow, KAckGap, KAckLast, KDlv, KEoiSetup, KEoiWr, KEoiHold} kind_t;

  kind_t      sched[$];
  kind_t      cur;
  bit         m_pend;
  bit         m_s1;
  bit         m_s2;
  logic [7:0] m_vec;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    cur    = KIdle;
    m_pend = 1'b0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_vec  = 8'h00;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    kind_t prev;
    prev = cur;
    if (prev == KIdle) begin
      if (m_pend) begin
        sched.push_back(KEoiSetup);
        for (int i = 0; i < P; i++) sched.push_back(KEoiWr);
        sched.push_back(KEoiHold);
      end else if (m_s2 && irq_enable) begin
        for (int i = 0; i < P; i++) sched.push_back(KAckLow);
        for (int i = 0; i < G; i++) sched.push_back(KAckGap);
        for (int i = 0; i < P - 1; i++) sched.push_back(KAckLow);
        sched.push_back(KAckLast);
      end
    end
    if (prev == KAckLast) m_vec = data_in;
    if (sched.size() != 0) cur = sched.pop_front();
    else if (prev == KAckLast || (prev == KDlv && !vector_ready)) cur = KDlv;
    else cur = KIdle;
    m_pend = (cur == KEoiSetup) ? 1'b0 : (m_pend | eoi_req);
    m_s2 = m_s1;
    m_s1 = int_req;
  endtask

  task automatic check_all();
    bit low_a;
    bit eoi_w;
    low_a = (cur == KAckLow) || (cur == KAckLast);
    eoi_w = (cur == KEoiSetup) || (cur == KEoiWr) || (cur == KEoiHold);
    chk("inta_n",       8'(inta_n),       8'(!low_a));
    chk("cs_n",         8'(cs_n),         8'(!eoi_w));
    chk("wr_n",         8'(wr_n),         8'(cur != KEoiWr));
    chk("a0",           8'(a0),           8'h00);
    chk("data_oe",      8'(data_oe),      8'(eoi_w));
    chk("data_out",     data_out,         eoi_w ? EOI : 8'h00);
    chk("vector_valid", 8'(vector_valid), 8'(cur == KDlv));
    chk("vector_out",   vector_out,       m_vec);
    chk("busy",         8'(busy),         8'(cur != KIdle));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    check_all();
  endtask

  int cs_cnt;
  int wr_cnt;
  int last_cs;
  int first_ack;

  initial begin
    model_reset();
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    irq_enable = 1'b1;
    tick();

    // Basic acknowledge: request at cycle 0, vector 0x4B driven by the PIC.
    int_req = 1'b1;
    data_in = 8'h4B;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_inta_timing", 8'(inta_n), (k == 3 || k == 4 || k == 6 || k == 7) ? 8'd0 : 8'd1);
    end
    chk("t1_vector", vector_out, 8'h4B);
    chk("t1_valid", 8'(vector_valid), 8'd1);

    // Core stalls for 5 cycles; no new acknowledge while the vector is outstanding.
    data_in = 8'hC3;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) int_req = 1'b0;
      tick();
      chk("t3_hold_valid", 8'(vector_valid), 8'd1);
      chk("t3_hold_vec", vector_out, 8'h4B);
      chk("t3_no_ack", 8'(inta_n), 8'd1);
    end
    vector_ready = 1'b1;
    tick();
    chk("t3_released", 8'(vector_valid), 8'd0);
    repeat (3) tick();

    // Interrupts masked: request ignored until enable rises.
    irq_enable = 1'b0;
    int_req    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t2_masked_inta", 8'(inta_n), 8'd1);
      chk("t2_masked_busy", 8'(busy), 8'd0);
    end
    irq_enable = 1'b1;
    data_in    = 8'h5A;
    tick();
    chk("t2_ack_start", 8'(inta_n), 8'd0);
    // Request and enable vanish mid-sequence; the handshake still completes.
    int_req    = 1'b0;
    irq_enable = 1'b0;
    repeat (10) tick();
    chk("t2_completed_vec", vector_out, 8'h5A);
    irq_enable = 1'b1;

    // EOI from IDLE.
    eoi_req = 1'b1;
    tick();
    eoi_req = 1'b0;
    cs_cnt = 0;
    wr_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!cs_n) cs_cnt++;
      if (!wr_n) wr_cnt++;
    end
    chk("t4_cs_width", 8'(cs_cnt), 8'(P + 2));
    chk("t4_wr_width", 8'(wr_cnt), 8'(P));
    chk("t4_idle_after", 8'(busy), 8'd0);

    // EOI and interrupt both pending: EOI first, one IDLE cycle, then ACK1.
    irq_enable = 1'b0;
    int_req    = 1'b1;
    repeat (3) tick();
    eoi_req = 1'b1;
    tick();
    eoi_req    = 1'b0;
    irq_enable = 1'b1;
    last_cs    = -1;
    first_ack  = -1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (!cs_n) last_cs = cycle;
      if (!inta_n && first_ack < 0) first_ack = cycle;
    end
    chk("t5_eoi_seen", 8'(last_cs >= 0), 8'd1);
    chk("t5_idle_gap", 8'(first_ack - last_cs), 8'd2);
    int_req = 1'b0;
    repeat (6) tick();

    // Reset in the middle of ACK2 drops all strobes at once and discards the vector.
    vector_ready = 1'b0;
    int_req      = 1'b1;
    data_in      = 8'h77;
    repeat (6) tick();
    chk("t6_in_ack2", 8'(inta_n), 8'd0);
    #2 rst = 1'b1;
    int_req = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_inta", 8'(inta_n), 8'd1);
    chk("t6_rst_valid", 8'(vector_valid), 8'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_no_vector", 8'(vector_valid), 8'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) int_req = ~int_req;
      irq_enable   = ($urandom_range(3) != 0);
      vector_ready = $urandom_range(1) == 1;
      eoi_req      = ($urandom_range(15) == 0);
      data_in      = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
